// File: rtl/vc_fifo_bank_if.sv
// Write/read request and status bundle of the virtual-channel FIFO bank.
// master drives requests (router/core side), slave is the FIFO bank.
interface vc_fifo_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CH_WIDTH   = 2
);
  localparam int NUM_CH = 1 << CH_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  logic                    wr_en;
  logic [CH_WIDTH-1:0]     wr_ch;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [CH_WIDTH-1:0]     rd_ch;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH*CNT_W-1:0] count;
  logic                    err_clr;
  logic                    ovf_err;
  logic                    udf_err;

  modport master (
    output wr_en, wr_ch, wr_data, rd_en, rd_ch, err_clr,
    input  rd_data, rd_valid, empty, full, almost_full, count, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rd_en, rd_ch, err_clr,
    output rd_data, rd_valid, empty, full, almost_full, count, ovf_err, udf_err
  );
endinterface

// File: rtl/vc_fifo_bank.sv
// Bank of 2**CH_WIDTH independent FIFOs sharing one statically partitioned RAM,
// with one write and one read per cycle, per-channel status and sticky errors.
module vc_fifo_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CH_WIDTH   = 2,
  parameter int AF_LEVEL   = 13
) (
  input logic            clk,
  input logic            rst,
  vc_fifo_bank_if.slave  bus
);
  localparam int NUM_CH = 1 << CH_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr [NUM_CH];
  logic [ADDR_WIDTH-1:0] rd_ptr [NUM_CH];
  logic [CNT_W-1:0]      cnt    [NUM_CH];

  logic [NUM_CH-1:0]       empty_v, full_v, af_v;
  logic [NUM_CH*CNT_W-1:0] count_v;
  logic                    rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic                    vld_p1;
  logic                    ovf_q, udf_q;

  always_comb begin
    empty_v = '0;
    full_v  = '0;
    af_v    = '0;
    count_v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty_v[c]                 = (cnt[c] == '0);
      full_v[c]                  = (cnt[c] == CNT_W'(DEPTH));
      af_v[c]                    = (cnt[c] >= CNT_W'(AF_LEVEL));
      count_v[c*CNT_W +: CNT_W]  = cnt[c];
    end
  end

  // A full channel still takes a write when the same channel is drained this cycle.
  assign rd_acc = bus.rd_en & ~empty_v[bus.rd_ch];
  assign wr_acc = bus.wr_en & (~full_v[bus.wr_ch] | (rd_acc & (bus.rd_ch == bus.wr_ch)));

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{bus.wr_ch, wr_ptr[bus.wr_ch]}] <= bus.wr_data;
  end

  // Stage p1: registered read port (old word on same-address collision).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rd_data_p1 <= mem[{bus.rd_ch, rd_ptr[bus.rd_ch]}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      if (wr_acc) wr_ptr[bus.wr_ch] <= wr_ptr[bus.wr_ch] + 1'b1;
      if (rd_acc) rd_ptr[bus.rd_ch] <= rd_ptr[bus.rd_ch] + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_acc && (bus.wr_ch == CH_WIDTH'(c)) && !(rd_acc && (bus.rd_ch == CH_WIDTH'(c))))
          cnt[c] <= cnt[c] + 1'b1;
        else if (rd_acc && (bus.rd_ch == CH_WIDTH'(c)) && !(wr_acc && (bus.wr_ch == CH_WIDTH'(c))))
          cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

  // Sticky errors: a new rejection outranks a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.err_clr) | (bus.wr_en & ~wr_acc);
      udf_q <= (udf_q & ~bus.err_clr) | (bus.rd_en & ~rd_acc);
    end
  end

  assign bus.rd_data     = rd_data_p1;
  assign bus.rd_valid    = vld_p1;
  assign bus.empty       = empty_v;
  assign bus.full        = full_v;
  assign bus.almost_full = af_v;
  assign bus.count       = count_v;
  assign bus.ovf_err     = ovf_q;
  assign bus.udf_err     = udf_q;
endmodule

// File: doc/vc_fifo_bank.md
Name: vc_fifo_bank

Overview:
- Multi-channel successor to the single-queue flit/data FIFO: 2**CH_WIDTH independent FIFOs (virtual channels) in one statically partitioned RAM.
- Sits at a router or core input port, buffering flits per virtual channel.
- One write and one read per cycle, to any channels, including the same channel.
- Adds per-channel full, per-channel programmable almost-full, occupancy outputs, a read-valid strobe, protected over/underflow and sticky error flags.

Parameters:
- DATA_WIDTH, 32, flit/word width in bits.
- ADDR_WIDTH, 4, log2 of per-channel depth; DEPTH = 2**ADDR_WIDTH = 16 entries per channel.
- CH_WIDTH, 2, log2 of channel count; NUM_CH = 2**CH_WIDTH = 4. Minimum 1.
- AF_LEVEL, 13, almost_full[c] asserts when count[c] >= AF_LEVEL. Range 1..DEPTH.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous reset, active-high.
- wr_en, in, 1, write request.
- wr_ch, in, CH_WIDTH, target channel of the write.
- wr_data, in, DATA_WIDTH, write data.
- rd_en, in, 1, read request.
- rd_ch, in, CH_WIDTH, source channel of the read.
- rd_data, out, DATA_WIDTH, read data; registered.
- rd_valid, out, 1, rd_data holds the word of a read accepted in the previous cycle.
- empty, out, NUM_CH, per channel: count == 0.
- full, out, NUM_CH, per channel: count == DEPTH.
- almost_full, out, NUM_CH, per channel: count >= AF_LEVEL.
- count, out, NUM_CH*(ADDR_WIDTH+1), packed occupancy; channel c is at bits [c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- err_clr, in, 1, clears the sticky error flags.
- ovf_err, out, 1, sticky: a write was rejected.
- udf_err, out, 1, sticky: a read was rejected.

Behaviour:
- Reset: on rst high at a clk edge, all pointers and counts go to 0, rd_valid=0, rd_data=0, ovf_err=0, udf_err=0.
  - After reset: empty = all 1, full = all 0, almost_full = all 0.
  - RAM contents are not reset.
  - Reset mid-operation discards all stored data; a read accepted in the reset cycle produces no rd_valid.
- Storage: one RAM of NUM_CH*DEPTH words. Channel c owns addresses {c, ptr}. Each channel has its own ADDR_WIDTH-bit wr_ptr and rd_ptr and an (ADDR_WIDTH+1)-bit count.
  - The count is one bit wider than the pointers, so all DEPTH entries are usable.
- Read acceptance: rd_acc = rd_en & ~empty[rd_ch], evaluated on pre-edge state.
- Write acceptance: wr_acc = wr_en & (~full[wr_ch] | (rd_acc & rd_ch == wr_ch)).
  - A write to a full channel is accepted when the same channel is read in the same cycle.
- Read of an empty channel with a simultaneous write to that channel: the read is rejected, the write is accepted, and udf_err is set.
- Rejected operations leave pointers, counts and RAM untouched.
  - A rejected write sets ovf_err; a rejected read sets udf_err.
  - Flags are set on the following edge and stay set until err_clr or rst.
  - If err_clr coincides with a new error, set wins.
- Accepted write: RAM[{wr_ch, wr_ptr}] <= wr_data; wr_ptr[wr_ch] increments and wraps modulo DEPTH.
- Accepted read: rd_data <= RAM[{rd_ch, rd_ptr}] on the same edge; rd_valid=1 for exactly the next cycle; rd_ptr[rd_ch] increments and wraps.
  - Latency: 1 cycle from rd_en to data.
  - rd_data holds its value when no read is accepted; rd_valid=0 in that case.
- Same-address write and read in one cycle (possible only when the channel is full): the read returns the old word, i.e. read-before-write.
- Count update per channel c:
  - +1 if a write is accepted to c and no read from c;
  - -1 if a read is accepted from c and no write to c;
  - unchanged otherwise, including a simultaneous write and read on c.
- Flags: empty, full, almost_full and count are combinational from the count registers, so they update in the cycle after the causing edge.

Test Plan:
- Reset, then write 0xA0..0xAF to ch1 on 16 consecutive cycles.
  - Expected: count[1] increments 1..16; almost_full[1] rises when count=13; full[1]=1 at 16; all other channels stay empty.
- Full ch1, then a 17th write of 0xBB alone.
  - Expected: write rejected, count stays 16, ovf_err=1 next cycle and remains set until err_clr pulses.
- Read ch1 16 times.
  - Expected: rd_data = 0xA0..0xAF in order, each one cycle after its rd_en with rd_valid=1; empty[1]=1 at the end. A 17th read gives rd_valid=0 and udf_err=1.
- Interleave writes to ch0 (0x10,0x11) and ch3 (0x30,0x31), then read ch3, ch0, ch3, ch0.
  - Expected: outputs 0x30, 0x10, 0x31, 0x11 — no cross-channel mixing.
- Full ch2, then simultaneous write 0xCC and read on ch2.
  - Expected: both accepted, count stays 16, the oldest word is returned, 0xCC emerges as the 16th subsequent read.
- Run 40 cycles of simultaneous write/read on ch0, then assert rst mid-stream.
  - Expected: pointers wrap cleanly and data order is preserved; after rst, all counts=0, rd_valid=0, error flags cleared.
